// File: rtl/rand_pkg.sv
// Shared types and constants for the random-byte arbiter and its 8-bit LFSR core.
package rand_pkg;

  localparam int              LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_RST  = 8'hFF;
  // Feedback taps: bits 4, 3, 2 and 0 are XORed into the new MSB.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } state_e;

endpackage

// File: rtl/rand_arbiter_lfsr8_core.sv
// 8-bit Fibonacci LFSR with synchronous load; a zero seed is replaced by the reset value.
module lfsr8_core
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_data,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);

  assign q_next = {^(q & LFSR_TAPS), q[LFSR_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= LFSR_RST;
    end else if (load) begin
      // All-zero is the lock-up state of this LFSR, so it is never loaded.
      q <= (load_data == '0) ? LFSR_RST : load_data;
    end else if (step) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one LFSR among NREQ requesters, STEPS shifts before each grant.
// Optional macro RAND_FREERUN_EN: LFSR also shifts on every IDLE cycle without a seed load.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int STEPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rdata,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = IDX_W + 1;
  localparam int CNT_W = 4;
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  state_e            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  step_cnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [CW-1:0]     cand;
  logic              lfsr_step;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;

  // Seed handshake: a seed transfers on any cycle with seed_valid && seed_ready;
  // seed_ready is high only in IDLE, and the seeder holds seed_valid until it sees it.
  assign seed_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign lfsr_load  = (state == IDLE) && seed_valid;

`ifdef RAND_FREERUN_EN
  assign lfsr_step = (state == STEP) || ((state == IDLE) && !seed_valid);
`else
  assign lfsr_step = (state == STEP);
`endif

  lfsr8_core u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .step      (lfsr_step),
    .load      (lfsr_load),
    .load_data (seed_data),
    .q         (lfsr_q),
    .q_next    (lfsr_nxt)
  );

  // First asserted request scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      step_cnt <= '0;
      gnt      <= '0;
      rdata    <= '0;
    end else begin
      gnt   <= '0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (!seed_valid && pick_found) begin
            idx      <= pick_idx;
            step_cnt <= CNT_W'(STEPS - 1);
            state    <= STEP;
          end
        end
        STEP: begin
          if (step_cnt == '0) begin
            state <= GRANT;
            // The pulse is registered, so it is decided on the edge that enters
            // GRANT; rdata takes the value produced by the final shift.
            if (req[idx]) begin
              gnt    <= GNT_ONE << idx;
              rdata  <= lfsr_nxt;
              rr_ptr <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
            end
          end else begin
            step_cnt <= step_cnt - CNT_W'(1);
          end
        end
        GRANT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter (NREQ=4, STEPS=4, RAND_FREERUN_EN undefined).
module tb_rand_arbiter;

  localparam int NREQ  = 4;
  localparam int STEPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rdata;
  logic       seed_valid = 1'b0;
  logic [7:0] seed_data = '0;
  logic       seed_ready;
  logic       busy;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  m_lfsr;
  int          m_rr;
  logic [11:0] exp_q[$];

  typedef struct {
    logic       seed_en;
    logic [7:0] seed;
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  logic [3:0] g;
  logic [7:0] d;
  int         e;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rand_arbiter #(.NREQ(NREQ), .STEPS(STEPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .rdata      (rdata),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_shift(input logic [7:0] v);
    logic b;
    b = v[4] ^ v[3] ^ v[2] ^ v[0];
    return (v >> 1) + (b ? 8'd128 : 8'd0);
  endfunction

  function automatic logic [7:0] ref_after(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = ref_shift(r);
    return r;
  endfunction

  function automatic int ref_pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req = '0;
    seed_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_lfsr = 8'hFF;
    m_rr   = 0;
  endtask

  // Counts rising edges from the current negedge until a grant is seen.
  task automatic wait_grant(output logic [3:0] gg, output logic [7:0] dd,
                            output int edges, input int limit);
    gg = '0;
    dd = '0;
    edges = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        gg = gnt;
        dd = rdata;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (seed_ready === 1'b1) return;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, seed_ready}, 32'd1);
  endtask

  task automatic do_seed(input logic [7:0] v);
    seed_data  = v;
    seed_valid = 1'b1;
    check("seed_ready_idle", {31'd0, seed_ready}, 32'd1);
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 8'h00, 4'b0001, 4'b0001, 8'h0F};
    vecs[1] = '{1'b0, 8'h00, 4'b0001, 4'b0001, 8'hD0};
    vecs[2] = '{1'b1, 8'h01, 4'b0100, 4'b0100, 8'h10};
    vecs[3] = '{1'b1, 8'h00, 4'b0001, 4'b0001, 8'h0F};
    vecs[4] = '{1'b0, 8'h00, 4'b1111, 4'b0010, 8'hD0};
    vecs[5] = '{1'b0, 8'h00, 4'b1001, 4'b1000, 8'h3D};
    vecs[6] = '{1'b0, 8'h00, 4'b0110, 4'b0010, 8'h63};

    // Reset values, checked right after release and before any clock edge.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_gnt",        {28'd0, gnt}, 32'd0);
    check("rst_rdata",      {24'd0, rdata}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_seed_ready", {31'd0, seed_ready}, 32'd1);
    check("rst_lfsr",       {24'd0, dut.lfsr_q}, 32'hFF);
    @(negedge clk);

    // Table of single transactions, applied in order from reset.
    reset_dut();
    foreach (vecs[i]) begin
      wait_idle();
      if (vecs[i].seed_en) do_seed(vecs[i].seed);
      req = vecs[i].req;
      wait_grant(g, d, e, 12);
      req = '0;
      check($sformatf("vec%0d_gnt", i),   {28'd0, g}, {28'd0, vecs[i].exp_gnt});
      check($sformatf("vec%0d_rdata", i), {24'd0, d}, {24'd0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_lat", i),   e, STEPS + 1);
    end

    // Held request: back-to-back grants to the same requester, 6 cycles apart.
    reset_dut();
    req = 4'b0001;
    wait_grant(g, d, e, 12);
    check("held0_rdata", {24'd0, d}, 32'h0F);
    check("held0_lat",   e, STEPS + 1);
    wait_grant(g, d, e, 12);
    check("held1_gnt",   {28'd0, g}, 32'h1);
    check("held1_rdata", {24'd0, d}, 32'hD0);
    check("held1_space", e, STEPS + 2);
    req = '0;

    // Round-robin with all requests held from reset.
    rst = 1'b0;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    begin
      logic [3:0] rr_g[5];
      logic [7:0] rr_d[5];
      rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_d = '{8'h0F, 8'hD0, 8'h3D, 8'h63, 8'h16};
      for (int i = 0; i < 5; i++) begin
        wait_grant(g, d, e, 12);
        check($sformatf("rr%0d_gnt", i),   {28'd0, g}, {28'd0, rr_g[i]});
        check($sformatf("rr%0d_rdata", i), {24'd0, d}, {24'd0, rr_d[i]});
        check($sformatf("rr%0d_space", i), e, (i == 0) ? STEPS + 1 : STEPS + 2);
      end
    end
    req = '0;

    // Seed and request together: seed wins, grant follows one cycle later.
    reset_dut();
    @(negedge clk);
    seed_data  = 8'h01;
    seed_valid = 1'b1;
    req        = 4'b0100;
    check("sr_seed_ready", {31'd0, seed_ready}, 32'd1);
    @(negedge clk);
    seed_valid = 1'b0;
    check("sr_still_idle", {31'd0, busy}, 32'd0);
    wait_grant(g, d, e, 12);
    req = '0;
    check("sr_gnt",   {28'd0, g}, 32'h4);
    check("sr_rdata", {24'd0, d}, 32'h10);
    check("sr_lat",   e, STEPS + 1);

    // Request drops during STEP, with a seed offered mid-STEP that must be ignored.
    reset_dut();
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("drop_busy", {31'd0, busy}, 32'd1);
    seed_data  = 8'h01;
    seed_valid = 1'b1;
    check("step_seed_ready", {31'd0, seed_ready}, 32'd0);
    @(negedge clk);
    check("step_seed_ready2", {31'd0, seed_ready}, 32'd0);
    seed_valid = 1'b0;
    req = '0;
    wait_grant(g, d, e, 8);
    check("drop_no_gnt", {28'd0, g}, 32'd0);
    wait_idle();
    req = 4'b1111;
    wait_grant(g, d, e, 12);
    req = '0;
    check("drop_rr_gnt",   {28'd0, g}, 32'h1);
    check("drop_rr_rdata", {24'd0, d}, 32'hD0);

    // Asynchronous reset in STEP, then in GRANT.
    reset_dut();
    @(negedge clk);
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check("ar_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_busy",       {31'd0, busy}, 32'd0);
    check("ar_seed_ready", {31'd0, seed_ready}, 32'd1);
    check("ar_lfsr",       {24'd0, dut.lfsr_q}, 32'hFF);
    check("ar_state",      {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_grant(g, d, e, 12);
    check("ar_next_rdata", {24'd0, d}, 32'h0F);
    check("ar_next_lat",   e, STEPS + 1);
    #2 rst = 1'b0;
    #1;
    check("ar_grant_gnt",   {28'd0, gnt}, 32'd0);
    check("ar_grant_rdata", {24'd0, rdata}, 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized transactions against the reference model.
    reset_dut();
    for (int it = 0; it < 60; it++) begin
      logic [3:0] r;
      logic [7:0] s;
      int         pk;
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        do_seed(s);
        m_lfsr = (s == 8'h00) ? 8'hFF : s;
      end
      r  = 4'($urandom_range(1, 15));
      pk = ref_pick(r, m_rr);
      m_lfsr = ref_after(m_lfsr, STEPS);
      if ($urandom_range(0, 4) == 0) begin
        req = r;
        repeat ($urandom_range(1, STEPS - 1)) @(negedge clk);
        req = '0;
        wait_grant(g, d, e, 8);
        check("rand_no_gnt", {28'd0, g}, 32'd0);
      end else begin
        exp_q.push_back({4'b0001 << pk, m_lfsr});
        m_rr = (pk + 1) % NREQ;
        req = r;
        wait_grant(g, d, e, 12);
        req = '0;
        check("rand_lat", e, STEPS + 1);
        if (exp_q.size() > 0) check("rand_grant", {20'd0, g, d}, {20'd0, exp_q.pop_front()});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
